// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: walks each packet through
// header decode, payload/parity load and parity check, and drives the write/busy strobes.
module router_fsm (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] LOAD_PARITY        = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] addr_q;
    logic [3:0] empty_vec;
    logic [3:0] srst_vec;
    logic       hdr_ok;
    logic       hdr_empty;
    logic       cur_empty;
    logic       cur_srst;

    // Slot 3 has no port: it reads as not-empty and never soft-resets.
    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    assign hdr_ok    = pkt_valid && (data_in != 2'd3);
    assign hdr_empty = empty_vec[data_in];
    assign cur_empty = empty_vec[addr_q];
    assign cur_srst  = srst_vec[addr_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= 2'd0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_q <= data_in;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok)
                    next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (cur_empty)
                    next_state = LOAD_FIRST_DATA;
            end
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        // Per-port read timeout aborts the packet from anywhere past header decode.
        if (state != DECODE_ADDRESS && cur_srst)
            next_state = DECODE_ADDRESS;
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: header accept, wait-till-empty, full stalls,
// parity path, soft reset selection and asynchronous reset.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int total = 0;
    int bad   = 0;
    int wr_cnt;

    // Output vector order: detect_add lfd ld laf full write_enb rst_int busy
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LAF = 8'b0001_0101;
    localparam logic [7:0] O_WTE = 8'b0000_0001;
    localparam logic [7:0] O_CPE = 8'b0000_0011;

    router_fsm dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [7:0] outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                       write_enb_reg, rst_int_reg, busy};

    task automatic chk(input string tag, input logic [7:0] exp);
        total++;
        assert (outs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (write_enb_reg) wr_cnt++;
    endtask

    initial begin
        rstn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0; wr_cnt = 0;
        #3;
        chk("reset", O_DA);
        rstn = 1'b1;
        step(); chk("idle", O_DA);

        // Packet to port 1, three payload bytes
        data_in = 2'd1; pkt_valid = 1'b1; wr_cnt = 0;
        step(); chk("p1_lfd", O_LFD);
        step(); chk("p1_ld1", O_LD);
        step(); chk("p1_ld2", O_LD);
        step(); chk("p1_ld3", O_LD);
        pkt_valid = 1'b0;
        step(); chk("p1_lp", O_LP);
        step(); chk("p1_cpe", O_CPE);
        step(); chk("p1_da", O_DA);
        total++;
        assert (wr_cnt == 4) else begin
            bad++;
            $error("FAIL p1_wr_cycles: observed=%0d expected=4", wr_cnt);
        end

        // Port 2 not empty: wait, then load
        data_in = 2'd2; pkt_valid = 1'b1; fifo_empty_2 = 1'b0;
        step(); chk("p2_wte0", O_WTE);
        pkt_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            step(); chk($sformatf("p2_wte%0d", i), O_WTE);
        end
        fifo_empty_2 = 1'b1;
        step(); chk("p2_lfd", O_LFD);
        pkt_valid = 1'b1;
        step(); chk("p2_ld", O_LD);

        // Full stall in LD, release to LAF, back to LD
        fifo_full = 1'b1;
        step(); chk("ffs0", O_FFS);
        for (int i = 1; i < 4; i++) begin
            step(); chk($sformatf("ffs%0d", i), O_FFS);
        end
        fifo_full = 1'b0;
        step(); chk("laf_a", O_LAF);
        step(); chk("laf_to_ld", O_LD);

        // LAF with low_pkt_valid -> LP -> CPE -> FFS (full) -> LAF -> DA (parity_done)
        fifo_full = 1'b1;
        step(); chk("ffs_b", O_FFS);
        fifo_full = 1'b0;
        step(); chk("laf_b", O_LAF);
        low_pkt_valid = 1'b1;
        step(); chk("laf_to_lp", O_LP);
        low_pkt_valid = 1'b0;
        step(); chk("lp_to_cpe", O_CPE);
        fifo_full = 1'b1;
        step(); chk("cpe_to_ffs", O_FFS);
        fifo_full = 1'b0;
        step(); chk("laf_c", O_LAF);
        parity_done = 1'b1;
        step(); chk("laf_to_da", O_DA);
        parity_done = 1'b0;

        // Address 3 never accepted
        data_in = 2'd3; pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("addr3_%0d", i), O_DA);
        end

        // Soft reset selection on port 0
        data_in = 2'd0;
        step(); chk("p0_lfd", O_LFD);
        step(); chk("p0_ld", O_LD);
        soft_reset_1 = 1'b1;
        step(); chk("srst1_ignored", O_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step(); chk("srst0_abort", O_DA);
        soft_reset_0 = 1'b0;

        // Soft reset beats the full transition out of LD
        step(); chk("p0b_lfd", O_LFD);
        step(); chk("p0b_ld", O_LD);
        fifo_full = 1'b1; soft_reset_0 = 1'b1;
        step(); chk("srst_priority", O_DA);
        soft_reset_0 = 1'b0; fifo_full = 1'b0;

        // Async reset mid-FFS
        step(); chk("p0c_lfd", O_LFD);
        step(); chk("p0c_ld", O_LD);
        fifo_full = 1'b1;
        step(); chk("p0c_ffs", O_FFS);
        #2 rstn = 1'b0;
        #1 chk("async_rst", O_DA);
        fifo_full = 1'b0; pkt_valid = 1'b0;
        step(); chk("held_rst", O_DA);
        rstn = 1'b1;
        step(); chk("post_rst", O_DA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
